// File: rtl/add_chain_seq_if.sv
// add_chain_seq_if
// Bundles the operand stream, the result stream, the abort strobe and the
// side-channel to the external 8-bit parallel adder into one interface.
//   slave  : the view used by add_chain_seq itself
//   master : the mirror view used by the surrounding environment
// Signals:
//   in_valid/in_ready/in_a/in_b/in_sub : operand byte-pair stream, LSB byte first
//   abort                              : synchronous abort of the current operation
//   add_a/add_b/add_cin                : drive to the adder
//   add_sum/add_cout                   : result from the adder
//   out_valid/out_ready/out_byte       : result byte stream
//   out_last/out_cout/out_zero         : final-byte marker and final flags
interface add_chain_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_sub;
  logic       abort;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_cout;
  logic       out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, abort, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin,
    output out_valid, out_byte, out_last, out_cout, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, abort, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin,
    input  out_valid, out_byte, out_last, out_cout, out_zero
  );
endinterface

// File: rtl/add_chain_seq.sv
// add_chain_seq
// Multi-byte add/subtract sequencer. Operand byte pairs arrive LSB first,
// are fed combinationally to an external 8-bit adder, and the adder's carry
// is chained into the next byte. Each result byte lands in a one-entry
// output buffer; the last (MSB) byte carries final carry/borrow and an
// all-bytes-zero flag.
// Parameters:
//   NBYTES : operand width in bytes (2..16)
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : add_chain_seq_if.slave (operand stream, result stream, abort, adder link)
// Build option:
//   ADD_CHAIN_SEQ_SUB_EN : when defined, in_sub on the first beat selects
//   A - B (as A + ~B + 1) and out_cout reports borrow. When undefined,
//   in_sub is ignored and only addition is performed.
module add_chain_seq #(
  parameter int NBYTES = 4
) (
  input logic            clk,
  input logic            rst,
  add_chain_seq_if.slave bus
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

  state_t          state_r;
  logic [IDXW-1:0] idx_r;
  logic            carry_r;
  logic            zero_r;
`ifdef ADD_CHAIN_SEQ_SUB_EN
  logic            sub_r;
`endif

  logic            out_valid_r;
  logic [7:0]      out_byte_r;
  logic            out_last_r;
  logic            out_cout_r;
  logic            out_zero_r;

  logic            first_s;
  logic            sub_eff_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            last_beat_s;
  logic            add_cin_s;
  logic            zero_acc_s;

  // Beat qualification, effective mode, carry selection and running zero flag
  always_comb begin
    first_s = (state_r == ST_FIRST);
`ifdef ADD_CHAIN_SEQ_SUB_EN
    // Mode comes live from the port on byte 0, then from the latched copy.
    if (first_s) begin
      sub_eff_s = bus.in_sub;
    end else begin
      sub_eff_s = sub_r;
    end
`else
    sub_eff_s = 1'b0;
`endif
    // Buffer can take a byte when empty or being drained this cycle;
    // abort blocks any beat offered alongside it.
    in_ready_s  = (!out_valid_r || bus.out_ready) && !bus.abort;
    accept_s    = bus.in_valid && in_ready_s;
    last_beat_s = (idx_r == LAST_IDX);
    // Initial carry is 1 for subtraction (the +1 of two's complement).
    if (first_s) begin
      add_cin_s  = sub_eff_s;
      zero_acc_s = (bus.add_sum == 8'h00);
    end else begin
      add_cin_s  = carry_r;
      zero_acc_s = zero_r && (bus.add_sum == 8'h00);
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.add_a     = bus.in_a;
  assign bus.add_b     = bus.in_b ^ {8{sub_eff_s}};
  assign bus.add_cin   = add_cin_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_byte  = out_byte_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_cout  = out_cout_r;
  assign bus.out_zero  = out_zero_r;

  // Sequencer FSM, carry chain state and one-entry output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FIRST;
      idx_r       <= {IDXW{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
`ifdef ADD_CHAIN_SEQ_SUB_EN
      sub_r       <= 1'b0;
`endif
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
      out_last_r  <= 1'b0;
      out_cout_r  <= 1'b0;
      out_zero_r  <= 1'b0;
    end else begin
      // Abort and accept are exclusive because in_ready is low during abort.
      if (bus.abort) begin
        state_r <= ST_FIRST;
        idx_r   <= {IDXW{1'b0}};
        carry_r <= 1'b0;
        zero_r  <= 1'b0;
`ifdef ADD_CHAIN_SEQ_SUB_EN
        sub_r   <= 1'b0;
`endif
      end else if (accept_s) begin
        carry_r <= bus.add_cout;
        zero_r  <= zero_acc_s;
        if (last_beat_s) begin
          idx_r   <= {IDXW{1'b0}};
          state_r <= ST_FIRST;
        end else begin
          idx_r   <= idx_r + IDXW'(1);
          state_r <= ST_CHAIN;
`ifdef ADD_CHAIN_SEQ_SUB_EN
          if (first_s) begin
            sub_r <= sub_eff_s;
          end
`endif
        end
      end

      // A push overrides a simultaneous pop so the stage runs without bubbles.
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_byte_r  <= bus.add_sum;
        out_last_r  <= last_beat_s;
        // Carry out XOR mode turns the subtract carry into a borrow.
        out_cout_r  <= last_beat_s & (bus.add_cout ^ sub_eff_s);
        out_zero_r  <= last_beat_s & zero_acc_s;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        out_cout_r  <= 1'b0;
        out_zero_r  <= 1'b0;
      end
    end
  end

endmodule
